// File: rtl/logic_result_buffer.sv
// rtl/logic_result_buffer.sv - tagged result FIFO between logic units and writeback
module logic_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_zero,
  output logic                       out_neg,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic             zero_mem [DEPTH];
  logic             neg_mem  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake qualifiers; in_ready depends only on stored state, never on out_ready.
  always_comb begin
    in_ready  = (count != CW'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Entry storage; flags are captured with the data so writeback sees push-time values.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_data;
      tag_mem[wr_ptr]  <= in_tag;
      zero_mem[wr_ptr] <= (in_data == '0);
      neg_mem[wr_ptr]  <= in_data[WIDTH-1];
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A push into a full buffer is dropped even if a pop frees a slot this cycle.
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // Fall-through head view; forced to zero when empty so stale entries never leak.
  always_comb begin
    out_data = '0;
    out_tag  = '0;
    out_zero = 1'b0;
    out_neg  = 1'b0;
    if (out_valid) begin
      out_data = data_mem[rd_ptr];
      out_tag  = tag_mem[rd_ptr];
      out_zero = zero_mem[rd_ptr];
      out_neg  = neg_mem[rd_ptr];
    end
  end

endmodule
